// File: rtl/calc_pkg.sv
// calc_pkg: shared width, opcode and FSM state definitions for the calculator ALU.
package calc_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;
endpackage

// File: rtl/calc_alu_if.sv
// calc_alu_if: request/result bundle between a requester and the calculator ALU.
interface calc_alu_if import calc_pkg::*; ();
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_error;
  modport master (output i_start, i_op, i_a, i_b, input o_busy, o_done, o_result, o_error);
  modport slave (input i_start, i_op, i_a, i_b, output o_busy, o_done, o_result, o_error);
endinterface

// File: rtl/calc_muldiv_core.sv
// calc_muldiv_core: one-bit-per-clock unsigned shift-add multiplier / restoring divider on magnitudes.
module calc_muldiv_core import calc_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               div_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] mag_o,
  output logic               last_o
);
  logic [WIDTH-1:0]   ma_q, mb_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [5:0]         cnt_q;
  logic               div_q;
  logic [WIDTH:0]     sum, trial, diff;
  // Upper half: product high / partial remainder; lower half: multiplier / dividend shifting into quotient.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff  = trial - {1'b0, mb_q};
    acc_d = div_q ? (diff[WIDTH] ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                  : {sum, acc_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_q  <= '0;
      mb_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      ma_q  <= a_i;
      mb_q  <= b_i;
      acc_q <= {{WIDTH{1'b0}}, div_i ? a_i : b_i};
      cnt_q <= '0;
      div_q <= div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 6'd1;
    end
  end
  assign mag_o  = div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
  assign last_o = cnt_q == 6'd31;
endmodule

// File: rtl/calc_alu.sv
// calc_alu: sequential signed add/sub/mul/div with overflow and divide-by-zero error flag.
module calc_alu import calc_pkg::*; (
  input logic       clock,
  input logic       reset,
  calc_alu_if.slave bus
);
  state_e             state_q;
  op_e                op_q;
  logic               sign_q, bz_q, busy_q, done_q, error_q;
  logic [WIDTH-1:0]   result_q, result_d, abs_a, abs_b, sum, diff, fix_res;
  logic               error_d, fix_err, mul_err, launch, last;
  logic [2*WIDTH-1:0] mag;
  always_comb begin
    launch   = state_q == S_IDLE && bus.i_start;
    abs_a    = bus.i_a[WIDTH-1] ? -bus.i_a : bus.i_a;
    abs_b    = bus.i_b[WIDTH-1] ? -bus.i_b : bus.i_b;
    sum      = bus.i_a + bus.i_b;
    diff     = bus.i_a - bus.i_b;
    result_d = bus.i_op[0] ? diff : sum;
    error_d  = bus.i_op[0] ? (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1] && diff[WIDTH-1] != bus.i_a[WIDTH-1])
                           : (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1] && sum[WIDTH-1] != bus.i_a[WIDTH-1]);
    // A negative result may reach magnitude 2^31, a positive one only 2^31-1.
    mul_err  = sign_q ? mag > 64'h8000_0000 : mag > 64'h7FFF_FFFF;
    fix_err  = op_q == OP_MUL ? mul_err : (bz_q || (!sign_q && mag[WIDTH-1]));
    fix_res  = sign_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
  end
  calc_muldiv_core u_core (
    .clk    (clock),
    .rst    (reset),
    .load_i (launch && bus.i_op[1]),
    .div_i  (bus.i_op[0]),
    .step_i (state_q == S_ITER),
    .a_i    (abs_a),
    .b_i    (abs_b),
    .mag_o  (mag),
    .last_o (last)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      sign_q   <= 1'b0;
      bz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (launch) begin
          op_q <= op_e'(bus.i_op);
          if (bus.i_op[1]) begin
            sign_q  <= bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1];
            bz_q    <= bus.i_b == '0;
            busy_q  <= 1'b1;
            state_q <= S_ITER;
          end else begin
            result_q <= error_d ? '0 : result_d;
            error_q  <= error_d;
            done_q   <= 1'b1;
          end
        end
        S_ITER: if (last) state_q <= S_FIX;
        S_FIX: begin
          result_q <= fix_err ? '0 : fix_res;
          error_q  <= fix_err;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign bus.o_result = result_q;
  assign bus.o_error  = error_q;
endmodule

// File: tb/tb_calc_alu.sv
// tb_calc_alu: scoreboard bench for calc_alu covering arithmetic, errors, latency, dropped starts and abort.
module tb_calc_alu;
  import calc_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  calc_alu_if bus ();
  calc_alu dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0;
  int errors = 0;
  int dones = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  always @(negedge clock) if (bus.o_done) begin
    dones++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done result=%h error=%b", bus.o_result, bus.o_error);
    end else begin
      exp_e = exp_q.pop_front();
      if ({bus.o_result, bus.o_error} !== exp_e) begin
        errors++;
        $display("FAIL scoreboard result=%h error=%b expected result=%h error=%b",
                 bus.o_result, bus.o_error, exp_e[32:1], exp_e[0]);
      end
    end
  end
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input bit push);
    @(negedge clock);
    if (push) exp_q.push_back({er, ee});
    bus.i_op = op;
    bus.i_a = a;
    bus.i_b = b;
    bus.i_start = 1'b1;
    @(posedge clock);
    #1 bus.i_start = 1'b0;
  endtask
  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = bus.o_busy ? 1 : 0;
    while (bus.o_done !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1 n++;
      if (bus.o_done !== 1'b1 && bus.o_busy === 1'b1) bc++;
    end
  endtask
  task automatic test_reset;
    bus.i_start = 1'b0;
    bus.i_op = 2'd0;
    bus.i_a = '0;
    bus.i_b = '0;
    #1;
    checks += 4;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    if (bus.o_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.o_result); end
    if (bus.o_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.o_error); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic test_add_sub;
    int n, bc;
    logic [1:0] ops[4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic [31:0] as[4] = '{32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'd10};
    logic [31:0] bs[4] = '{32'hFFFF_FFF4, 32'd1, 32'd1, 32'd3};
    logic [31:0] rs[4] = '{32'hFFFF_FFFB, 32'h0, 32'h0, 32'd7};
    logic es[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], as[i], bs[i], rs[i], es[i], 1'b1);
      wait_done(n, bc);
      checks += 2;
      if (n != 0) begin errors++; $display("FAIL addsub_latency[%0d] got %0d want 0", i, n); end
      if (bc != 0) begin errors++; $display("FAIL addsub_busy[%0d] got %0d want 0", i, bc); end
    end
  endtask
  task automatic test_muldiv;
    int n, bc;
    logic [1:0] ops[6] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] as[6] = '{-32'sd1234, 32'd65536, -32'sd65536, -32'sd100, 32'd5, 32'h8000_0000};
    logic [31:0] bs[6] = '{32'd5678, 32'd32768, 32'd32768, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] rs[6] = '{-32'sd7006652, 32'h0, 32'h8000_0000, -32'sd14, 32'h0, 32'h0};
    logic es[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      launch(ops[i], as[i], bs[i], rs[i], es[i], 1'b1);
      wait_done(n, bc);
      checks += 2;
      if (n != 33) begin errors++; $display("FAIL muldiv_latency[%0d] got %0d want 33", i, n); end
      if (bc != 33) begin errors++; $display("FAIL muldiv_busy[%0d] got %0d want 33", i, bc); end
    end
  endtask
  task automatic test_start_while_busy;
    int n, bc, d0;
    launch(2'd2, 32'd300000, -32'sd7, 32'hFFDF_F4E0, 1'b0, 1'b1);
    d0 = dones;
    repeat (10) @(posedge clock);
    @(negedge clock);
    bus.i_start = 1'b1;
    bus.i_op = 2'd3;
    bus.i_a = 32'd99;
    bus.i_b = 32'd3;
    @(negedge clock);
    bus.i_start = 1'b0;
    bus.i_a = 32'd1;
    bus.i_b = 32'd1;
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL dropped_start_busy got %b want 1", bus.o_busy); end
    wait_done(n, bc);
    repeat (5) @(negedge clock);
    checks++;
    if (dones != d0 + 1) begin errors++; $display("FAIL dropped_start_dones got %0d want %0d", dones - d0, 1); end
  endtask
  task automatic test_reset_abort;
    int n, bc, d0;
    launch(2'd3, 32'd1000, 32'd3, 32'h0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (bus.o_result !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 0", bus.o_result); end
    if (bus.o_error !== 1'b0) begin errors++; $display("FAIL abort_error got %b want 0", bus.o_error); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.o_busy); end
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", bus.o_done); end
    @(negedge clock);
    reset = 1'b0;
    d0 = dones;
    repeat (40) @(negedge clock);
    checks++;
    if (dones != d0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones - d0); end
    launch(2'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
    wait_done(n, bc);
    checks++;
    if (n != 0) begin errors++; $display("FAIL post_abort_latency got %0d want 0", n); end
  endtask
  initial begin
    test_reset;
    test_add_sub;
    test_muldiv;
    test_start_while_busy;
    test_reset_abort;
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pending_results got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_alu.md
# calc_alu

Sequential signed arithmetic unit of the calculator. It accepts two 32-bit two's-complement operands and an opcode, computes add, subtract, multiply or divide, and presents a 32-bit signed result plus an error flag. It sits directly upstream of the 7-segment display driver. `o_result` feeds that driver's `value` input and `o_error` feeds its `error` input. Multiply and divide are iterative, one bit per clock, on operand magnitudes.

## Interface
- `WIDTH`, default 32: operand/result width. Only 32 is supported and verified.
- `clock`, in, 1: 50 MHz system clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset of all state.
- `i_start`, in, 1: request a new operation. Sampled only in IDLE.
- `i_op`, in, 2: opcode. 0 = ADD, 1 = SUB, 2 = MUL, 3 = DIV.
- `i_a`, in, 32: signed left operand (dividend, minuend).
- `i_b`, in, 32: signed right operand (divisor, subtrahend).
- `o_busy`, out, 1: high while an operation is in progress. `i_start` is ignored while it is high.
- `o_done`, out, 1: single-cycle pulse when `o_result`/`o_error` update.
- `o_result`, out, 32: signed result. Holds its value until the next completion.
- `o_error`, out, 1: error flag for the last operation. Holds until the next completion.

## Operation
- States: IDLE, ITER, FIX.
- **IDLE**, on `i_start`: capture `i_op`, `i_a`, `i_b`.
  - ADD/SUB: compute and register the result at this same edge, then stay in IDLE.
  - MUL/DIV:
    - load |a| and |b| into 32-bit magnitude registers (|−2^31| = 2^31, unsigned);
    - record result sign = a[31] XOR b[31];
    - clear the 6-bit iteration counter;
    - go to ITER.
- **ITER**, 32 cycles:
  - MUL: shift-add into a 64-bit unsigned accumulator, LSB of |b| first.
  - DIV: restoring division, MSB of |a| first. 32-bit quotient; 33-bit partial remainder.
  - The counter increments each cycle. Leave to FIX when the counter reaches 31.
- **FIX**, 1 cycle: apply the sign (two's-complement negate if the sign bit is set), evaluate errors, register outputs, return to IDLE.
- Arithmetic rules:
  - ADD/SUB: 32-bit wrap. Error on signed overflow, i.e. operand signs match (ADD) or differ (SUB) and the result sign differs from a.
  - MUL: error if magnitude > 2^31−1 with a positive result, or > 2^31 with a negative result. Otherwise the result is the low 32 bits after sign application.
  - DIV: truncation toward zero; the remainder is discarded.
    - `i_b == 0` raises error. The iteration still runs its full length, so latency is fixed.
    - Quotient magnitude 2^31 with a positive sign raises error (covers −2^31 / −1).
  - On any error: `o_result` = 0, `o_error` = 1.
- Operand changes after capture are ignored.
- `i_start` asserted while busy is dropped, not queued.
- `i_start` held high in IDLE re-launches an operation every time IDLE is re-entered.

## Timing
- Reset values: state IDLE; `o_busy` = 0, `o_done` = 0, `o_result` = 0, `o_error` = 0; internal registers 0.
- Reset mid-operation aborts immediately. No `o_done` is issued for the aborted operation.
- ADD/SUB: call the start-sampling edge E1. Outputs update at E1. `o_done` is high for the cycle after E1. `o_busy` stays 0.
- MUL/DIV:
  - ITER occupies edges E2–E33; FIX registers outputs at E34.
  - `o_busy` is high from after E1 until E34.
  - `o_done` is high for the cycle after E34. A new `i_start` can be sampled at E35.
- `o_done` is never high for more than one consecutive cycle, except for back-to-back ADD/SUB.

## Structure
- Shared package `calc_pkg`:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`;
  - state encoding;
  - `WIDTH`.
- One sub-module, `calc_muldiv_core`. It owns the magnitude registers, the 64-bit accumulator / partial remainder and the counter. Interface: load, mode, step, magnitude result out. `calc_alu` keeps the FSM, sign handling and error logic.

## Test plan
- ADD 7 + (−12) → `o_result` = −5 (0xFFFFFFFB), `o_error` = 0, `o_done` in the cycle after start; then ADD 0x7FFFFFFF + 1 → `o_result` = 0, `o_error` = 1.
- MUL −1234 × 5678 → `o_result` = −7006652. `o_done` exactly 34 edges after the start edge; `o_busy` high for that span.
- MUL 65536 × 32768 → `o_result` = 0, `o_error` = 1 (2^31 positive). MUL −65536 × 32768 → −2^31, `o_error` = 0.
- DIV −100 / 7 → −14. DIV 5 / 0 → `o_error` = 1, same 34-edge latency. DIV 0x80000000 / −1 → `o_error` = 1.
- Start a MUL, pulse `i_start` with a DIV at ITER cycle 10, change operands mid-run → MUL result unaffected; exactly one `o_done`.
- Assert `reset` during ITER of a DIV → outputs 0 asynchronously, no `o_done`. A following ADD 2 + 3 → 5 with normal latency.
